// File: rtl/int_issue_pkg.sv
// Shared definitions for the integer issue/execute block: widths, opcodes and FSM states.
package int_issue_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TAG_W  = 6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_CDB_REQ = 2'd2
  } state_t;

endpackage

// File: rtl/int_issue_exec_block_alu.sv
// Combinational integer ALU/multiplier; every opcode wraps modulo 2^DATA_W.
module int_alu
  import int_issue_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic [4:0] shamt;
  logic       slt;

  assign shamt = b[4:0];
  assign slt   = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    case (opcode)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLT:  result = {{(DATA_W-1){1'b0}}, slt};
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_MUL:  result = a * b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/int_issue_exec_block.sv
// Single-entry, non-pipelined integer execute stage: captures a ready queue entry,
// executes it (MUL takes MUL_LATENCY cycles) and broadcasts the result on the CDB.
module int_issue_exec_block
  import int_issue_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int MUL_LATENCY = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issueque_ready,
  input  logic [2:0]        issue_opcode,
  input  logic [TAG_W-1:0]  issue_rd_tag,
  input  logic [DATA_W-1:0] issue_rs1_data,
  input  logic [DATA_W-1:0] issue_rs2_data,
  output logic              issueblk_done,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              CDB_valid,
  output logic [TAG_W-1:0]  CDB_tag,
  output logic [DATA_W-1:0] CDB_data,
  output logic              busy
);

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] alu_res;

  int_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    tag_d   = tag_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (issueque_ready) begin
          op_d    = issue_opcode;
          tag_d   = issue_rd_tag;
          a_d     = issue_rs1_data;
          b_d     = issue_rs2_data;
          cnt_d   = (issue_opcode == OP_MUL) ? MUL_CNT_INIT : 4'd0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_d   = alu_res;
          state_d = ST_CDB_REQ;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CDB_REQ: begin
        if (cdb_grant) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  // Outputs are gated by reset so a dropped instruction never requests or broadcasts.
  assign issueblk_done = (state_q == ST_IDLE) && issueque_ready && !reset;
  assign cdb_req       = (state_q == ST_CDB_REQ) && !reset;
  assign CDB_valid     = cdb_req && cdb_grant;
  assign CDB_tag       = CDB_valid ? tag_q : '0;
  assign CDB_data      = CDB_valid ? res_q : '0;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_int_issue_exec_block.sv
// Self-checking bench: timeline-based reference model checked every cycle, plus directed literal scenarios.
module tb_int_issue_exec_block;
  import int_issue_pkg::*;

  localparam int DATA_W      = 32;
  localparam int TAG_W       = 6;
  localparam int MUL_LATENCY = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              issueque_ready;
  logic [2:0]        issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic              issueblk_done;
  logic              cdb_req;
  logic              cdb_grant;
  logic              CDB_valid;
  logic [TAG_W-1:0]  CDB_tag;
  logic [DATA_W-1:0] CDB_data;
  logic              busy;

  int_issue_exec_block #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .issueque_ready(issueque_ready),
    .issue_opcode(issue_opcode), .issue_rd_tag(issue_rd_tag),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issueblk_done(issueblk_done), .cdb_req(cdb_req), .cdb_grant(cdb_grant),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: at most one instruction in flight, eligible for the CDB from a known cycle on.
  bit                m_have = 1'b0;
  int                m_ready_cyc = 0;
  logic [TAG_W-1:0]  m_tag = '0;
  logic [DATA_W-1:0] m_res = '0;

  int                done_log[$];
  int                bc_cyc_log[$];
  logic [TAG_W-1:0]  bc_tag_log[$];
  logic [DATA_W-1:0] bc_data_log[$];

  function automatic logic [DATA_W-1:0] refResult(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
    logic [4:0]  sh;
    logic [63:0] prod;
    sh   = b[4:0];
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLL:  return a << sh;
      OP_SRL:  return a >> sh;
      default: return prod[31:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : cmp_proc
    logic              e_done, e_req, e_valid, e_busy;
    logic [TAG_W-1:0]  e_tag;
    logic [DATA_W-1:0] e_data;
    e_done = 1'b0; e_req = 1'b0; e_valid = 1'b0; e_busy = m_have;
    e_tag  = '0;   e_data = '0;
    if (!reset) begin
      if (!m_have) begin
        e_done = issueque_ready;
      end else if (cyc >= m_ready_cyc) begin
        e_req   = 1'b1;
        e_valid = cdb_grant;
        e_tag   = cdb_grant ? m_tag : '0;
        e_data  = cdb_grant ? m_res : '0;
      end
    end
    checkOutput("issueblk_done", issueblk_done, e_done);
    checkOutput("cdb_req", cdb_req, e_req);
    checkOutput("CDB_valid", CDB_valid, e_valid);
    checkOutput("CDB_tag", CDB_tag, e_tag);
    checkOutput("CDB_data", CDB_data, e_data);
    if (!reset) checkOutput("busy", busy, e_busy);

    if (issueblk_done) done_log.push_back(cyc);
    if (CDB_valid) begin
      bc_cyc_log.push_back(cyc);
      bc_tag_log.push_back(CDB_tag);
      bc_data_log.push_back(CDB_data);
    end

    if (reset) begin
      m_have = 1'b0;
    end else if (!m_have && issueque_ready) begin
      m_have      = 1'b1;
      m_ready_cyc = cyc + 1 + ((issue_opcode == OP_MUL) ? MUL_LATENCY : 1);
      m_tag       = issue_rd_tag;
      m_res       = refResult(issue_opcode, issue_rs1_data, issue_rs2_data);
    end else if (m_have && cyc >= m_ready_cyc && cdb_grant) begin
      m_have = 1'b0;
    end
    cyc++;
  end

  task automatic applyStimulus(input logic rdy, input logic [2:0] op, input logic [TAG_W-1:0] tag,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic gnt, input logic rst);
    issueque_ready = rdy;
    issue_opcode   = op;
    issue_rd_tag   = tag;
    issue_rs1_data = a;
    issue_rs2_data = b;
    cdb_grant      = gnt;
    reset          = rst;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic runOne(input logic [2:0] op, input logic [TAG_W-1:0] tag,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        output logic [DATA_W-1:0] data, output logic [TAG_W-1:0] t,
                        output int lat, output int nbc);
    int d0, b0;
    d0 = done_log.size();
    b0 = bc_cyc_log.size();
    applyStimulus(1'b1, op, tag, a, b, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
    repeat (MUL_LATENCY + 4) stepCycle();
    nbc  = bc_cyc_log.size() - b0;
    data = '0;
    t    = '0;
    lat  = -1;
    if (nbc >= 1 && done_log.size() > d0) begin
      data = bc_data_log[b0];
      t    = bc_tag_log[b0];
      lat  = bc_cyc_log[b0] - done_log[d0];
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    logic [DATA_W-1:0] r_data;
    logic [TAG_W-1:0]  r_tag;
    int                r_lat, r_nbc, d0, b0, hits;
    logic [TAG_W-1:0]  q_tag[$];
    logic [DATA_W-1:0] q_a[$];

    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b0, 1'b1);
    repeat (3) stepCycle();
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b0, 1'b0);
    #3;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_cdb_req", cdb_req, 1'b0);
    stepCycle();

    runOne(OP_ADD, 6'd12, 32'd5, 32'd7, r_data, r_tag, r_lat, r_nbc);
    checkOutput("add_data", r_data, 32'd12);
    checkOutput("add_tag", r_tag, 6'd12);
    checkOutput("add_latency", r_lat, 2);
    checkOutput("add_count", r_nbc, 1);

    runOne(OP_SUB, 6'd3, 32'd0, 32'd1, r_data, r_tag, r_lat, r_nbc);
    checkOutput("sub_wrap_data", r_data, 32'hFFFF_FFFF);
    runOne(OP_SLT, 6'd4, 32'hFFFF_FFFF, 32'd1, r_data, r_tag, r_lat, r_nbc);
    checkOutput("slt_data", r_data, 32'd1);
    runOne(OP_SLL, 6'd5, 32'h0000_0003, 32'h0000_0124, r_data, r_tag, r_lat, r_nbc);
    checkOutput("sll_data", r_data, 32'h0000_0030);

    runOne(OP_MUL, 6'd33, 32'd6, 32'd7, r_data, r_tag, r_lat, r_nbc);
    checkOutput("mul_data", r_data, 32'd42);
    checkOutput("mul_tag", r_tag, 6'd33);
    checkOutput("mul_latency", r_lat, 2 + MUL_LATENCY - 1);

    // Grant withheld while the queue keeps offering an entry.
    applyStimulus(1'b1, OP_ADD, 6'd7, 32'd100, 32'd23, 1'b0, 1'b0);
    #3 checkOutput("gw_capture_done", issueblk_done, 1'b1);
    stepCycle();
    #3 checkOutput("gw_exec_done", issueblk_done, 1'b0);
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      #3;
      checkOutput("gw_req_held", cdb_req, 1'b1);
      checkOutput("gw_done_held", issueblk_done, 1'b0);
      stepCycle();
    end
    cdb_grant = 1'b1;
    #3;
    checkOutput("gw_valid", CDB_valid, 1'b1);
    checkOutput("gw_data", CDB_data, 32'd123);
    checkOutput("gw_grant_done", issueblk_done, 1'b0);
    stepCycle();
    #3 checkOutput("gw_done_after", issueblk_done, 1'b1);
    stepCycle();
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
    repeat (5) stepCycle();

    // Reset while a MUL is executing drops it silently.
    b0 = bc_cyc_log.size();
    applyStimulus(1'b1, OP_MUL, 6'd40, 32'd9, 32'd9, 1'b1, 1'b0);
    stepCycle();
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b1);
    #3;
    checkOutput("rst_exec_done", issueblk_done, 1'b0);
    checkOutput("rst_exec_req", cdb_req, 1'b0);
    stepCycle();
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
    #3;
    checkOutput("rst_after_busy", busy, 1'b0);
    checkOutput("rst_after_valid", CDB_valid, 1'b0);
    repeat (6) stepCycle();
    hits = 0;
    for (int i = b0; i < bc_tag_log.size(); i++) if (bc_tag_log[i] == 6'd40) hits++;
    checkOutput("rst_no_broadcast", hits, 0);

    // Back-to-back stream of three ADDs popped from a queue on issueblk_done.
    d0 = done_log.size();
    b0 = bc_cyc_log.size();
    q_tag = '{6'd20, 6'd21, 6'd22};
    q_a   = '{32'd1, 32'd2, 32'd3};
    for (int i = 0; i < 20; i++) begin
      if (q_tag.size() > 0) applyStimulus(1'b1, OP_ADD, q_tag[0], q_a[0], 32'd10, 1'b1, 1'b0);
      else                  applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
      #3;
      if (issueblk_done && q_tag.size() > 0) begin
        void'(q_tag.pop_front());
        void'(q_a.pop_front());
      end
      stepCycle();
    end
    checkOutput("b2b_done_count", done_log.size() - d0, 3);
    checkOutput("b2b_bc_count", bc_cyc_log.size() - b0, 3);
    if (done_log.size() - d0 == 3 && bc_cyc_log.size() - b0 == 3) begin
      checkOutput("b2b_spacing1", done_log[d0+1] - done_log[d0], 3);
      checkOutput("b2b_spacing2", done_log[d0+2] - done_log[d0+1], 3);
      for (int i = 0; i < 3; i++) begin
        checkOutput("b2b_tag", bc_tag_log[b0+i], 6'(20 + i));
        checkOutput("b2b_data", bc_data_log[b0+i], 32'(11 + i));
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 6'($urandom),
                    $urandom, $urandom, $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
      stepCycle();
    end
    applyStimulus(1'b0, OP_ADD, '0, '0, '0, 1'b1, 1'b0);
    repeat (MUL_LATENCY + 4) stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_issue_exec_block.md
Name: int_issue_exec_block

Overview:
- Downstream consumer of the integer issue queue's shift/update control.
- When the queue signals a ready entry, this block captures it, executes it on a single integer ALU/multiplier and arbitrates for the common data bus (CDB).
- It broadcasts tag and result on the CDB and returns issueblk_done to the queue so the selected entry is removed.
- Holds one instruction at a time and is non-pipelined.

Parameters:
DATA_W, 32, operand/result width
TAG_W, 6, physical register tag width
MUL_LATENCY, 3, cycles spent in EXEC for MUL (legal range 1..15)

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
issueque_ready  input  1  queue has a ready entry, selected by data_sel upstream
issue_opcode  input  3  opcode of the selected entry
issue_rd_tag  input  TAG_W  destination tag of the selected entry
issue_rs1_data  input  DATA_W  operand 1 of the selected entry
issue_rs2_data  input  DATA_W  operand 2 of the selected entry
issueblk_done  output  1  entry captured this cycle; queue shifts it out
cdb_req  output  1  request for the CDB
cdb_grant  input  1  CDB arbiter grant; sampled only while cdb_req=1
CDB_valid  output  1  broadcast valid
CDB_tag  output  TAG_W  broadcast tag
CDB_data  output  DATA_W  broadcast result
busy  output  1  state != IDLE

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, SLT=4 (signed, result 0/1), SLL=5, SRL=6, MUL=7.
- All arithmetic wraps modulo 2^DATA_W. SLL/SRL use rs2[4:0] as shift amount. MUL keeps the low DATA_W bits of the product.
- States: IDLE, EXEC, CDB_REQ. Reset forces IDLE, clears cnt, res_q, tag_q, op_q.
- Reset values of all outputs are 0.
- issueblk_done = (state==IDLE) & issueque_ready & !reset. It is combinational, so the queue shifts in the same cycle the entry is captured.
- IDLE, with issueque_ready=1 at an edge:
  - latch opcode, rd_tag and both operands;
  - go to EXEC with cnt = (opcode==MUL) ? MUL_LATENCY-1 : 0.
- IDLE, with issueque_ready=0: stay in IDLE.
- EXEC:
  - when cnt==0: compute the result from the latched operands, register it into res_q, go to CDB_REQ;
  - otherwise decrement cnt.
  - Non-MUL ops spend 1 cycle in EXEC; MUL spends MUL_LATENCY cycles.
- CDB_REQ:
  - cdb_req=1.
  - If cdb_grant=1 in a cycle: CDB_valid=1, CDB_tag=tag_q, CDB_data=res_q that cycle, and the next state is IDLE.
  - If cdb_grant=0: hold, with CDB_valid=0, CDB_tag=0, CDB_data=0.
- CDB outputs are zero whenever CDB_valid=0.
- Latency for a non-MUL op with immediate grant: capture edge → EXEC (1 cycle) → CDB_REQ with grant. The broadcast happens 2 cycles after the issueblk_done cycle. MUL adds MUL_LATENCY-1 cycles.
- Throughput is one instruction per at least 3 cycles. issueblk_done is never asserted outside IDLE, including in the grant cycle.
- Operand inputs are ignored outside IDLE. cdb_grant is ignored when cdb_req=0.
- Reset asserted mid-EXEC or mid-CDB_REQ:
  - next cycle is IDLE;
  - the in-flight instruction is dropped with no broadcast;
  - issueblk_done and cdb_req are 0 during the reset cycle.
- Grant withheld indefinitely: stay in CDB_REQ and never accept a new entry. Back-pressure reaches the queue through issueblk_done=0.

Decomposition:
- Shared package int_issue_pkg holds:
  - DATA_W and TAG_W defaults;
  - opcode localparams OP_ADD..OP_MUL;
  - state encodings ST_IDLE=2'd0, ST_EXEC=2'd1, ST_CDB_REQ=2'd2.
- One sub-module, int_alu: combinational, with inputs opcode, a, b and output result. It covers all opcodes including MUL.
- The top level handles the FSM, the MUL latency counter and the result register.

Test Plan:
- ADD: rs1=5, rs2=7, rd_tag=6'd12, grant held at 1 → issueblk_done pulses 1 cycle; 2 cycles later CDB_valid=1, CDB_tag=12, CDB_data=12.
- SUB wrap: rs1=0, rs2=1 → CDB_data=32'hFFFFFFFF. SLT: rs1=-1, rs2=1 → CDB_data=1.
- MUL with MUL_LATENCY=3: 6×7, tag 33 → exactly 3 cycles in EXEC, then CDB_data=42, CDB_tag=33.
- Grant withheld 4 cycles with issueque_ready held at 1 → cdb_req stays 1 and issueblk_done stays 0 for all 4 cycles. On grant, the broadcast occurs, and issueblk_done pulses on the next (IDLE) cycle.
- Reset asserted in EXEC of a MUL → next cycle state IDLE; no CDB_valid for that tag; all outputs 0.
- Back-to-back stream of 3 ADDs with grant held at 1 → exactly 3 issueblk_done pulses spaced 3 cycles apart, and 3 broadcasts in order with correct tags.
